sort_result_collector: RTL and testbench
========================================

// Module: sort_result_collector
// PURPOSE
//  Downstream stage of the 32-entry colour bubble sorter. Captures one sorted frame, i.e. NUM_ENTRIES
//  beats of {image index, colour class}, into a local buffer while building a 4-bin colour histogram.
//  Then replays the frame in rank order over a valid/ready stream to the display/host logic.
//  Decouples the sorter's free-running output burst from a back-pressuring consumer.
// PARAMETERS
//  NUM_ENTRIES  32  beats per frame (power of two)
//  IDX_W        5   image index width, log2(NUM_ENTRIES)
//  COLOR_W      2   colour class width (fixed 4 bins)
//  CNT_W        6   histogram counter width, clog2(NUM_ENTRIES+1)
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              asynchronous, active-high
//  in_valid     in   1              sorter beat strobe; qualifies in_index/in_color this cycle
//  in_index     in   IDX_W          original image index of this rank
//  in_color     in   COLOR_W        colour class of this rank
//  out_valid    out  1              replay beat available
//  out_ready    in   1              consumer accepts beat
//  out_index    out  IDX_W          buffered image index at out_rank
//  out_color    out  COLOR_W        buffered colour class at out_rank
//  out_rank     out  IDX_W          rank of current beat, 0 = smallest
//  out_last     out  1              out_rank == NUM_ENTRIES-1
//  hist_counts  out  4*CNT_W        {bin3,bin2,bin1,bin0} colour counts of the captured frame
//  hist_valid   out  1              hist_counts complete for the current frame
//  frame_done   out  1              one-cycle pulse after the last replay handshake
//  overflow     out  1              sticky: a beat arrived while in DRAIN and was dropped
//  busy         out  1              state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=rd_ptr=0, all outputs 0, buffer contents don't-care.
//  States: IDLE -> COLLECT -> DRAIN -> IDLE.
//   IDLE: in_valid writes buf[0]. Histogram is cleared, then bin[in_color] is set to 1.
//         hist_valid drops to 0 and wr_ptr becomes 1. Next state is COLLECT.
//   COLLECT: each in_valid writes buf[wr_ptr] and increments bin[in_color]; beats may be non-contiguous.
//         The write at wr_ptr==NUM_ENTRIES-1 moves to DRAIN, sets hist_valid=1 and wraps wr_ptr to 0.
//   DRAIN: out_valid=1 from the first cycle after the last capture edge (1-cycle latency).
//         out_* are read from buf[rd_ptr] with no further latency.
//         A handshake (out_valid&out_ready) increments rd_ptr.
//         The handshake with out_last=1 wraps rd_ptr to 0, returns to IDLE and pulses frame_done next cycle.
//         out_* must hold stable while out_valid&!out_ready.
//  out_valid=0 outside DRAIN; out_index/out_color/out_rank/out_last then drive 0.
//  hist_counts hold their final values until the first beat of the next frame. Counters never exceed NUM_ENTRIES.
//  in_valid in DRAIN (including the cycle of the final handshake): beat dropped, overflow<=1.
//  overflow clears only on reset.
//  Reset mid-frame: frame is abandoned and the block returns to reset values immediately (async).
// STRUCTURE
//  Shared package sort_pkg: NUM_ENTRIES, IDX_W, COLOR_W, CNT_W constants.
//  Also in sort_pkg: collector state enum {IDLE,COLLECT,DRAIN} and the entry struct {index, color}.
//  Sub-module color_histogram: 4 x CNT_W counters with clear, inc and bin-select inputs.
//  Top holds the FSM, pointers and the NUM_ENTRIES x (IDX_W+COLOR_W) register buffer.
// TESTING
//  1 Reset, then 32 contiguous beats index=31-r, color=r[1:0], out_ready=1.
//    -> out_valid rises 1 cycle after beat 31; out_index=31..0 in order; out_last on rank 31.
//    -> hist_counts = 8/8/8/8; frame_done pulses once; busy=0 after.
//  2 Beats with random in_valid gaps, all color=2 -> hist bin2=32, others 0; replay order matches capture order.
//  3 out_ready toggling 1/0 every cycle -> 32 handshakes; out_* stable while stalled; frame_done after 64 cycles.
//  4 in_valid asserted during DRAIN -> beat not captured, overflow=1 and sticky across the next full frame.
//    -> replay data unchanged.
//  5 Assert reset after 10 captured beats -> all outputs 0 at once; a subsequent full frame replays correctly.
//  6 Two back-to-back frames -> hist_valid drops on the first beat of frame 2.
//    -> frame 1 counts held until then; frame 2 replay shows only frame 2 data.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg
//   Shared constants and types for the colour sorter result path.
//   NUM_ENTRIES : beats per sorted frame (power of two)
//   IDX_W       : image index width, log2(NUM_ENTRIES)
//   COLOR_W     : colour class width (4 bins)
//   CNT_W       : histogram counter width, wide enough to hold NUM_ENTRIES
package sort_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int IDX_W       = 5;
  localparam int COLOR_W     = 2;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } coll_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]   index;
    logic [COLOR_W-1:0] color;
  } entry_t;

endpackage

// File: rtl/color_histogram.sv
// color_histogram
//   Four saturating colour-class counters for one captured frame.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     clear      : restart the histogram; combined with inc the selected bin starts at 1
//     inc        : count one beat into bin_sel
//     bin_sel    : colour class of the beat being counted
//     counts     : {bin3, bin2, bin1, bin0}
module color_histogram
  import sort_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  input  logic [COLOR_W-1:0] bin_sel,
  output logic [4*CNT_W-1:0] counts
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_ENTRIES);

  logic [CNT_W-1:0] bin_q [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 4; b++) bin_q[b] <= '0;
    end else if (clear) begin
      for (int b = 0; b < 4; b++)
        bin_q[b] <= (inc && bin_sel == COLOR_W'(b)) ? CNT_W'(1) : '0;
    end else if (inc && bin_q[bin_sel] != CNT_MAX) begin
      // Saturate so a malformed upstream burst cannot wrap a bin.
      bin_q[bin_sel] <= bin_q[bin_sel] + CNT_W'(1);
    end
  end

  assign counts = {bin_q[3], bin_q[2], bin_q[1], bin_q[0]};

endmodule

// File: rtl/sort_result_collector.sv
// sort_result_collector
//   Captures one sorted frame of {image index, colour class} beats from the
//   bubble sorter, builds a colour histogram, then replays the frame in rank
//   order over a valid/ready stream.
//   Ports:
//     clk, reset          : clock, asynchronous active-high reset
//     in_valid            : sorter beat strobe for in_index / in_color
//     out_valid/out_ready : replay handshake
//     out_index/out_color : buffered entry at out_rank (0 when not replaying)
//     out_rank, out_last  : rank of current beat, last-rank flag
//     hist_counts         : {bin3,bin2,bin1,bin0} of the captured frame
//     hist_valid          : histogram complete for the current frame
//     frame_done          : pulse after the final replay handshake
//     overflow            : sticky, a beat arrived during replay and was dropped
//     busy                : not idle
//
//   state   | meaning
//   IDLE    | waiting for the first beat of a frame (written to entry 0)
//   COLLECT | capturing beats 1..NUM_ENTRIES-1, gaps allowed
//   DRAIN   | replaying the buffer; incoming beats are dropped
module sort_result_collector
  import sort_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_index,
  input  logic [COLOR_W-1:0] in_color,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_index,
  output logic [COLOR_W-1:0] out_color,
  output logic [IDX_W-1:0]   out_rank,
  output logic               out_last,
  output logic [4*CNT_W-1:0] hist_counts,
  output logic               hist_valid,
  output logic               frame_done,
  output logic               overflow,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_ENTRIES - 1);

  coll_state_e      state_q, state_d;
  logic [IDX_W-1:0] wr_ptr, rd_ptr;
  entry_t           frame_buf [NUM_ENTRIES];
  entry_t           rd_entry;

  logic in_idle, in_collect, in_drain;
  logic capture, last_wr, handshake, rd_last;

  assign in_idle    = (state_q == IDLE);
  assign in_collect = (state_q == COLLECT);
  assign in_drain   = (state_q == DRAIN);

  assign capture   = in_valid && (in_idle || in_collect);
  assign last_wr   = in_valid && in_collect && (wr_ptr == LAST_PTR);
  assign rd_last   = in_drain && (rd_ptr == LAST_PTR);
  assign handshake = in_drain && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)             state_d = COLLECT;
      COLLECT: if (last_wr)              state_d = DRAIN;
      DRAIN:   if (handshake && rd_last) state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hist_valid <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (in_idle && in_valid) begin
        wr_ptr     <= IDX_W'(1);
        hist_valid <= 1'b0;
      end else if (last_wr) begin
        wr_ptr     <= '0;
        hist_valid <= 1'b1;
      end else if (capture) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
      end

      if (handshake) rd_ptr <= rd_last ? '0 : rd_ptr + IDX_W'(1);

      frame_done <= handshake && rd_last;

      if (in_valid && in_drain) overflow <= 1'b1;
    end
  end

  // Frame storage needs no reset; contents are only read after a full capture.
  always_ff @(posedge clk) begin
    if (capture) frame_buf[wr_ptr] <= '{index: in_index, color: in_color};
  end

  color_histogram u_hist (
    .clk     (clk),
    .reset   (reset),
    .clear   (in_idle && in_valid),
    .inc     (capture),
    .bin_sel (in_color),
    .counts  (hist_counts)
  );

  assign rd_entry  = frame_buf[rd_ptr];
  assign out_valid = in_drain;
  assign out_index = in_drain ? rd_entry.index : '0;
  assign out_color = in_drain ? rd_entry.color : '0;
  assign out_rank  = in_drain ? rd_ptr : '0;
  assign out_last  = rd_last;
  assign busy      = !in_idle;

endmodule

// File: tb/tb_sort_result_collector.sv
module tb_sort_result_collector;
  import sort_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [IDX_W-1:0]   in_index;
  logic [COLOR_W-1:0] in_color;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_index;
  logic [COLOR_W-1:0] out_color;
  logic [IDX_W-1:0]   out_rank;
  logic               out_last;
  logic [4*CNT_W-1:0] hist_counts;
  logic               hist_valid;
  logic               frame_done;
  logic               overflow;
  logic               busy;

  sort_result_collector dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_index    (in_index),
    .in_color    (in_color),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_color   (out_color),
    .out_rank    (out_rank),
    .out_last    (out_last),
    .hist_counts (hist_counts),
    .hist_valid  (hist_valid),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] idx;
    logic [1:0] col;
    logic [4:0] rank;
    logic       last;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        sb_e;
  int          checks   = 0;
  int          errors   = 0;
  int          fd_count = 0;
  int          rank_ctr = 0;
  int          vcyc;
  logic        stall_prev = 1'b0;
  logic [12:0] held;
  logic [4:0]  b_idx;
  logic [1:0]  b_col;

  localparam logic [23:0] H_8888  = {6'd8,  6'd8, 6'd8,  6'd8};
  localparam logic [23:0] H_BIN2  = {6'd0,  6'd32, 6'd0, 6'd0};
  localparam logic [23:0] H_SKEW  = {6'd4,  6'd0, 6'd12, 6'd16};
  localparam logic [23:0] H_ODDEV = {6'd16, 6'd0, 6'd0,  6'd16};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold during stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (frame_done) fd_count++;
        if (stall_prev)
          chk("stall_hold", {19'd0, out_index, out_color, out_rank, out_last}, {19'd0, held});
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL replay_empty: unexpected beat rank %0d, expected none", out_rank);
          end else begin
            sb_e = sb_q.pop_front();
            chk("replay", {19'd0, out_index, out_color, out_rank, out_last}, {19'd0, sb_e});
          end
        end
        stall_prev = out_valid && !out_ready;
        held       = {out_index, out_color, out_rank, out_last};
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic get_beat(input int pat, input int r, output logic [4:0] idx, output logic [1:0] col);
    case (pat)
      0: begin idx = 5'(31 - r); col = 2'(r); end
      1: begin idx = 5'(r);      col = 2'd2;  end
      2: begin idx = 5'(r * 7);  col = (r < 4) ? 2'd3 : (r < 16) ? 2'd1 : 2'd0; end
      default: begin idx = ~5'(r); col = (r % 2 == 1) ? 2'd3 : 2'd0; end
    endcase
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [4:0] idx, input logic [1:0] col);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_index = idx;
    in_color = col;
    sb_q.push_back({idx, col, 5'(rank_ctr), rank_ctr == 31});
    rank_ctr = (rank_ctr + 1) % 32;
  endtask

  // Leaves the bench in the first replay cycle with in_valid low.
  task automatic send_frame(input int pat, input bit gaps);
    logic [4:0] idx;
    logic [1:0] col;
    for (int r = 0; r < 32; r++) begin
      if (gaps) repeat ($urandom_range(0, 3)) idle_cycle();
      get_beat(pat, r, idx, col);
      send_beat(idx, col);
    end
    idle_cycle();
  endtask

  // mode 0: ready always high; mode 1: ready low on the first replay cycle, then toggling.
  // inject_cyc >= 0 drives a stray beat on that replay cycle.
  task automatic drain(input int mode, input int inject_cyc, output int vcycles);
    bit done = 0;
    vcycles = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      out_ready = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
      in_valid  = (cyc == inject_cyc);
      in_index  = 5'h1F;
      in_color  = 2'd3;
      @(negedge clk);
      if (out_valid) vcycles++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (frame_done) done = 1;
    end
    out_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: frame_done not seen, expected within 300 cycles");
    end
    @(posedge clk); #1;
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_index  = '0;
    in_color  = '0;
    out_ready = 1'b1;
    #1;
    chk("reset_outputs", {out_valid, out_index, out_color, out_rank, out_last, hist_valid,
                          frame_done, overflow, busy}, 32'd0);
    chk("reset_hist", {8'd0, hist_counts}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // 1: contiguous frame, index 31-r, colour r[1:0]
    for (int r = 0; r < 32; r++) begin
      get_beat(0, r, b_idx, b_col);
      send_beat(b_idx, b_col);
      if (r == 31) begin
        @(negedge clk);
        chk("valid_before_last_edge", {31'd0, out_valid}, 32'd0);
      end
    end
    idle_cycle();
    chk("valid_latency", {31'd0, out_valid}, 32'd1);
    chk("first_index", {27'd0, out_index}, 32'd31);
    chk("hist_valid_set", {31'd0, hist_valid}, 32'd1);
    drain(0, -1, vcyc);
    chk("t1_drain_cycles", vcyc, 32);
    chk("t1_hist", {8'd0, hist_counts}, {8'd0, H_8888});
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_frame_done_count", fd_count, 1);
    chk("t1_overflow_clear", {31'd0, overflow}, 32'd0);

    // 2: random gaps, all colour 2
    send_frame(1, 1'b1);
    drain(0, -1, vcyc);
    chk("t2_hist", {8'd0, hist_counts}, {8'd0, H_BIN2});
    chk("t2_hist_valid", {31'd0, hist_valid}, 32'd1);

    // 3: toggling ready
    send_frame(2, 1'b0);
    drain(1, -1, vcyc);
    chk("t3_drain_cycles", vcyc, 64);
    chk("t3_hist", {8'd0, hist_counts}, {8'd0, H_SKEW});

    // 4: stray beat during a stalled replay cycle, then during the final handshake
    send_frame(3, 1'b0);
    drain(1, 4, vcyc);
    chk("t4_overflow_set", {31'd0, overflow}, 32'd1);
    chk("t4_hist", {8'd0, hist_counts}, {8'd0, H_ODDEV});
    send_frame(0, 1'b0);
    drain(0, 31, vcyc);
    chk("t4_overflow_sticky", {31'd0, overflow}, 32'd1);
    chk("t4_busy_after_drop", {31'd0, busy}, 32'd0);
    chk("t4_hist_after_drop", {8'd0, hist_counts, 7'd0, hist_valid}, {8'd0, H_8888, 8'd1});

    // 5: reset after 10 captured beats
    for (int r = 0; r < 10; r++) begin
      get_beat(2, r, b_idx, b_col);
      send_beat(b_idx, b_col);
    end
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t5_reset_outputs", {out_valid, out_index, out_color, out_rank, out_last, hist_valid,
                             frame_done, overflow, busy}, 32'd0);
    chk("t5_reset_hist", {8'd0, hist_counts}, 32'd0);
    sb_q.delete();
    rank_ctr = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    send_frame(3, 1'b0);
    drain(0, -1, vcyc);
    chk("t5_hist", {8'd0, hist_counts}, {8'd0, H_ODDEV});

    // 6: back-to-back frames
    send_frame(2, 1'b0);
    drain(0, -1, vcyc);
    chk("t6_f1_hist_held", {8'd0, hist_counts, 7'd0, hist_valid}, {8'd0, H_SKEW, 8'd1});
    for (int r = 0; r < 32; r++) begin
      get_beat(1, r, b_idx, b_col);
      send_beat(b_idx, b_col);
      if (r == 0) begin
        @(negedge clk);
        chk("t6_hist_before_f2", {8'd0, hist_counts, 7'd0, hist_valid}, {8'd0, H_SKEW, 8'd1});
      end
      if (r == 1)
        chk("t6_hist_restart", {8'd0, hist_counts, 7'd0, hist_valid},
            {8'd0, 6'd0, 6'd1, 6'd0, 6'd0, 8'd0});
    end
    idle_cycle();
    drain(0, -1, vcyc);
    chk("t6_f2_hist", {8'd0, hist_counts}, {8'd0, H_BIN2});

    repeat (3) idle_cycle();
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("frame_done_total", fd_count, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
